ram_loader: RTL and testbench

- Address/write-control front end sitting directly upstream of the 16-byte RAM module. Drives its data, address, ram_in and ram_out inputs.
- Run mode: holds the memory address register (MAR), loaded from the CPU bus, and passes the CPU RAM controls through.
- Program mode: accepts a byte stream over a valid/ready handshake and writes it into consecutive RAM locations starting at address 0.

---
 rtl/ram_loader.sv | 129 ++++++++++++
 tb/tb_ram_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// Address/write-control front end for the 16-byte RAM: CPU passthrough with MAR
// in run mode, sequential byte loader over a valid/ready handshake in program mode.
module ram_loader #(
  parameter int unsigned RAM_INPUT_ADDR = 4,
  parameter int unsigned RAM_SIZE       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      prog_mode,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  input  logic [7:0]                bus_data,
  input  logic                      mar_in,
  input  logic                      cpu_ram_in,
  input  logic                      cpu_ram_out,
  output logic [7:0]                ram_data,
  output logic [RAM_INPUT_ADDR-1:0] ram_address,
  output logic                      ram_in,
  output logic                      ram_out,
  output logic                      load_done,
  output logic [RAM_INPUT_ADDR:0]   bytes_written
);

  localparam int unsigned AW  = RAM_INPUT_ADDR;
  localparam int unsigned CW  = RAM_INPUT_ADDR + 1;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [AW-1:0] PTR_LAST = AW'(RAM_SIZE - 1);

  logic [1:0]    state, state_next;
  logic [AW-1:0] mar, mar_next;
  logic [AW-1:0] ptr, ptr_next;
  logic [7:0]    hold, hold_next;
  logic [CW-1:0] count_next;
  logic          done_next;
  logic          ram_in_c, ram_out_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_next;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar           <= '0;
      ptr           <= '0;
      hold          <= '0;
      bytes_written <= '0;
      load_done     <= 1'b0;
    end else begin
      mar           <= mar_next;
      ptr           <= ptr_next;
      hold          <= hold_next;
      bytes_written <= count_next;
      load_done     <= done_next;
    end
  end

  // Next-state and RAM-side control decode
  always_comb begin
    state_next  = state;
    mar_next    = mar;
    ptr_next    = ptr;
    hold_next   = hold;
    count_next  = bytes_written;
    done_next   = load_done;
    ram_data    = bus_data;
    ram_address = mar;
    ram_in_c    = 1'b0;
    ram_out_c   = 1'b0;
    in_ready    = 1'b0;

    case (state)
      ST_RUN: begin
        ram_in_c  = cpu_ram_in;
        ram_out_c = cpu_ram_out;
        if (mar_in) mar_next = bus_data[AW-1:0];
        if (prog_mode) begin
          state_next = ST_LOAD;
          ptr_next   = '0;
          count_next = '0;
          done_next  = 1'b0;
        end
      end
      ST_LOAD: begin
        in_ready    = 1'b1;
        ram_address = ptr;
        // Abort has priority over an offered byte
        if (!prog_mode) begin
          state_next = ST_RUN;
        end else if (in_valid) begin
          hold_next  = in_data;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        ram_in_c    = 1'b1;
        ram_address = ptr;
        ram_data    = hold;
        count_next  = bytes_written + CW'(1);
        if (ptr == PTR_LAST) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
        end else begin
          ptr_next   = ptr + AW'(1);
          state_next = ST_LOAD;
        end
      end
      ST_DONE: begin
        ram_address = ptr;
        ram_data    = hold;
        if (!prog_mode) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  // RAM strobes are held off for the whole reset assertion
  assign ram_in  = rst_n & ram_in_c;
  assign ram_out = rst_n & ram_out_c;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with a behavioural 16-byte RAM attached to its outputs.
module tb_ram_loader;

  logic       clk;
  logic       rst_n;
  logic       prog_mode;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] bus_data;
  logic       mar_in;
  logic       cpu_ram_in;
  logic       cpu_ram_out;
  logic [7:0] ram_data;
  logic [3:0] ram_address;
  logic       ram_in;
  logic       ram_out;
  logic       load_done;
  logic [4:0] bytes_written;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [16];
  logic [7:0] ram_rd;

  ram_loader #(.RAM_INPUT_ADDR(4), .RAM_SIZE(16)) dut (
    .clk(clk), .rst_n(rst_n), .prog_mode(prog_mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .bus_data(bus_data), .mar_in(mar_in), .cpu_ram_in(cpu_ram_in),
    .cpu_ram_out(cpu_ram_out), .ram_data(ram_data), .ram_address(ram_address),
    .ram_in(ram_in), .ram_out(ram_out), .load_done(load_done),
    .bytes_written(bytes_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM downstream of the loader
  always @(posedge clk) if (ram_in) mem[ram_address] <= ram_data;
  assign ram_rd = ram_out ? mem[ram_address] : 8'h00;

  function automatic logic [7:0] gap_byte(input int i);
    return 8'(8'hC3 ^ (i * 17));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic read_ram(input logic [3:0] a, output logic [7:0] d);
    bus_data = {4'h0, a};
    mar_in   = 1'b1;
    tick();
    mar_in      = 1'b0;
    cpu_ram_out = 1'b1;
    @(negedge clk);
    d = ram_rd;
    tick();
    cpu_ram_out = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; prog_mode = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    cpu_ram_in = 1'b1; cpu_ram_out = 1'b1; bus_data = 8'h2B; mar_in = 1'b1;
    @(negedge clk);
    total++;
    if ({ram_in, ram_out, in_ready} !== 3'b000) begin
      bad++; $display("FAIL reset_strobes got=%b want=000", {ram_in, ram_out, in_ready});
    end
    total++;
    if ({ram_address, load_done, bytes_written} !== 10'h000) begin
      bad++; $display("FAIL reset_regs addr=%h done=%b bw=%0d want 0/0/0", ram_address, load_done, bytes_written);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({ram_in, ram_out, ram_address} !== 6'b11_0000) begin
      bad++; $display("FAIL reset_release got in=%b out=%b addr=%h want 1/1/0", ram_in, ram_out, ram_address);
    end
    tick();
    mar_in = 1'b0; cpu_ram_in = 1'b0; cpu_ram_out = 1'b0;
  endtask

  task automatic test_run_mode;
    @(negedge clk);
    total++;
    if (ram_address !== 4'hB) begin
      bad++; $display("FAIL run_mar got=%h want=b", ram_address);
    end
    cpu_ram_in = 1'b1; bus_data = 8'h5A;
    @(negedge clk);
    total++;
    if ({ram_in, ram_data} !== 9'h15A) begin
      bad++; $display("FAIL run_write got in=%b data=%h want 1/5a", ram_in, ram_data);
    end
    tick();
    cpu_ram_in = 1'b0; cpu_ram_out = 1'b1; bus_data = 8'h00;
    @(negedge clk);
    total++;
    if (ram_rd !== 8'h5A) begin
      bad++; $display("FAIL run_read got=%h want=5a", ram_rd);
    end
    tick();
    cpu_ram_out = 1'b0;
  endtask

  task automatic test_full_program;
    logic [7:0] d;
    prog_mode = 1'b1; in_valid = 1'b1; in_data = 8'h10;
    tick();
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(8'h10 + i);
      @(negedge clk);
      total++;
      if ({in_ready, ram_in} !== 2'b10) begin
        bad++; $display("FAIL full_load%0d got rdy=%b in=%b want 1/0", i, in_ready, ram_in);
      end
      tick();
      @(negedge clk);
      total++;
      if ({ram_in, in_ready, ram_address, ram_data} !== {1'b1, 1'b0, 4'(i), 8'(8'h10 + i)}) begin
        bad++; $display("FAIL full_write%0d got in=%b rdy=%b addr=%h data=%h want 1/0/%h/%h",
                        i, ram_in, in_ready, ram_address, ram_data, 4'(i), 8'(8'h10 + i));
      end
      tick();
    end
    @(negedge clk);
    total++;
    if ({load_done, bytes_written, in_ready} !== {1'b1, 5'd16, 1'b0}) begin
      bad++; $display("FAIL full_done got done=%b bw=%0d rdy=%b want 1/16/0", load_done, bytes_written, in_ready);
    end
    prog_mode = 1'b0; in_valid = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      read_ram(4'(i), d);
      total++;
      if (d !== 8'(8'h10 + i)) begin
        bad++; $display("FAIL full_readback%0d got=%h want=%h", i, d, 8'(8'h10 + i));
      end
    end
  endtask

  task automatic test_gaps_overflow;
    logic [7:0] d;
    prog_mode = 1'b1; in_valid = 1'b0; in_data = 8'hEE;
    tick();
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < i % 3; g++) begin
        in_valid = 1'b0; in_data = 8'hEE;
        @(negedge clk);
        total++;
        if ({in_ready, ram_in} !== 2'b10) begin
          bad++; $display("FAIL gap_bubble%0d got rdy=%b in=%b want 1/0", i, in_ready, ram_in);
        end
        tick();
      end
      in_valid = 1'b1; in_data = gap_byte(i);
      tick();
      in_valid = 1'b0; in_data = 8'hEE;
      @(negedge clk);
      total++;
      if ({ram_in, ram_address, ram_data} !== {1'b1, 4'(i), gap_byte(i)}) begin
        bad++; $display("FAIL gap_write%0d got in=%b addr=%h data=%h want 1/%h/%h",
                        i, ram_in, ram_address, ram_data, 4'(i), gap_byte(i));
      end
      tick();
    end
    in_valid = 1'b1; in_data = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({in_ready, ram_in} !== 2'b00) begin
        bad++; $display("FAIL overflow%0d got rdy=%b in=%b want 0/0", k, in_ready, ram_in);
      end
      tick();
    end
    total++;
    if ({load_done, bytes_written} !== {1'b1, 5'd16}) begin
      bad++; $display("FAIL overflow_count got done=%b bw=%0d want 1/16", load_done, bytes_written);
    end
    prog_mode = 1'b0; in_valid = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      read_ram(4'(i), d);
      total++;
      if (d !== gap_byte(i)) begin
        bad++; $display("FAIL gap_readback%0d got=%h want=%h", i, d, gap_byte(i));
      end
    end
  endtask

  task automatic test_abort;
    logic [7:0] d;
    bus_data = 8'h07; mar_in = 1'b1;
    tick();
    mar_in = 1'b0; prog_mode = 1'b1;
    tick();
    // CPU controls toggled while the loader owns the RAM
    cpu_ram_in = 1'b1; cpu_ram_out = 1'b1; mar_in = 1'b1; bus_data = 8'h0C;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h50 + i);
      @(negedge clk);
      total++;
      if ({ram_in, ram_out, in_ready} !== 3'b001) begin
        bad++; $display("FAIL abort_load%0d got in=%b out=%b rdy=%b want 0/0/1", i, ram_in, ram_out, in_ready);
      end
      tick();
      in_valid = 1'b0;
      if (i == 4) prog_mode = 1'b0;
      @(negedge clk);
      total++;
      if ({ram_in, ram_address, ram_data} !== {1'b1, 4'(i), 8'(8'h50 + i)}) begin
        bad++; $display("FAIL abort_write%0d got in=%b addr=%h data=%h want 1/%h/%h",
                        i, ram_in, ram_address, ram_data, 4'(i), 8'(8'h50 + i));
      end
      tick();
    end
    in_valid = 1'b1; in_data = 8'hEE;
    @(negedge clk);
    total++;
    if (ram_in !== 1'b0) begin
      bad++; $display("FAIL abort_priority got in=%b want 0", ram_in);
    end
    tick();
    mar_in = 1'b0; cpu_ram_in = 1'b0; cpu_ram_out = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, load_done, bytes_written, ram_address} !== {1'b0, 1'b0, 5'd5, 4'h7}) begin
      bad++; $display("FAIL abort_state got rdy=%b done=%b bw=%0d addr=%h want 0/0/5/7",
                      in_ready, load_done, bytes_written, ram_address);
    end
    read_ram(4'd4, d);
    total++;
    if (d !== 8'h54) begin
      bad++; $display("FAIL abort_ram4 got=%h want=54", d);
    end
    read_ram(4'd5, d);
    total++;
    if (d !== gap_byte(5)) begin
      bad++; $display("FAIL abort_ram5 got=%h want=%h", d, gap_byte(5));
    end
  endtask

  task automatic test_reset_mid_write;
    logic [7:0] d;
    prog_mode = 1'b1; in_valid = 1'b1; in_data = 8'h61;
    tick();
    tick();
    tick();
    in_data = 8'h62;
    tick();
    in_valid = 1'b0; cpu_ram_in = 1'b1;
    @(negedge clk);
    total++;
    if ({ram_in, ram_address, bytes_written} !== {1'b1, 4'h1, 5'd1}) begin
      bad++; $display("FAIL midrst_pre got in=%b addr=%h bw=%0d want 1/1/1", ram_in, ram_address, bytes_written);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({ram_in, in_ready, load_done, bytes_written, ram_address} !== 12'h000) begin
      bad++; $display("FAIL midrst_async got in=%b rdy=%b done=%b bw=%0d addr=%h want all 0",
                      ram_in, in_ready, load_done, bytes_written, ram_address);
    end
    tick();
    prog_mode = 1'b0; cpu_ram_in = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, ram_in, ram_address} !== 6'b00_0000) begin
      bad++; $display("FAIL midrst_run got rdy=%b in=%b addr=%h want 0/0/0", in_ready, ram_in, ram_address);
    end
    tick();
    read_ram(4'd0, d);
    total++;
    if (d !== 8'h61) begin
      bad++; $display("FAIL midrst_ram0 got=%h want=61", d);
    end
    read_ram(4'd1, d);
    total++;
    if (d !== 8'h51) begin
      bad++; $display("FAIL midrst_ram1 got=%h want=51", d);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_reset();
    test_run_mode();
    test_full_program();
    test_gaps_overflow();
    test_abort();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
